// File: rtl/crop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : crop_pkg                                                  |
// | Purpose  : Shared types for the crop frame controller: FSM states,   |
// |            crop window record and window validation helper.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package crop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } crop_state_e;

  // Window fields are carried at a fixed width wide enough for any frame
  // size; the sum type has one extra bit so x1+w cannot wrap.
  localparam int unsigned CROP_DIM_W = 16;
  typedef logic [CROP_DIM_W-1:0] crop_dim_t;
  typedef logic [CROP_DIM_W:0]   crop_sum_t;

  typedef struct packed {
    crop_dim_t x1;
    crop_dim_t y1;
    crop_dim_t w;
    crop_dim_t h;
  } crop_win_t;

  // A window is legal when non-empty and fully inside the frame.
  function automatic logic crop_win_ok(input crop_win_t win,
                                       input crop_sum_t cols,
                                       input crop_sum_t rows);
    crop_sum_t x_end;
    crop_sum_t y_end;
    x_end = {1'b0, win.x1} + {1'b0, win.w};
    y_end = {1'b0, win.y1} + {1'b0, win.h};
    return (win.w != '0) && (win.h != '0) && (x_end <= cols) && (y_end <= rows);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crop_window_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : crop_window_regs                                          |
// | Purpose  : Pending/active crop window registers. Validates config    |
// |            writes, flags rejects, and copies pending to active on a  |
// |            load strobe from the frame sequencer.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module crop_window_regs
  import crop_pkg::*;
#(
  parameter int IN_ROWS = 40,
  parameter int IN_COLS = 40,
  parameter int DEF_X1  = 10,
  parameter int DEF_Y1  = 10,
  parameter int DEF_W   = 20,
  parameter int DEF_H   = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_wr_i,
  input  logic [$clog2(IN_COLS)-1:0]   cfg_x1_i,
  input  logic [$clog2(IN_ROWS)-1:0]   cfg_y1_i,
  input  logic [$clog2(IN_COLS+1)-1:0] cfg_w_i,
  input  logic [$clog2(IN_ROWS+1)-1:0] cfg_h_i,
  input  logic                         load_i,
  output crop_win_t                    act_win_o,
  output logic                         cfg_err_o
);

  localparam crop_win_t c_def_win = '{
    x1: crop_dim_t'(DEF_X1),
    y1: crop_dim_t'(DEF_Y1),
    w:  crop_dim_t'(DEF_W),
    h:  crop_dim_t'(DEF_H)
  };
  localparam crop_sum_t c_cols = crop_sum_t'(IN_COLS);
  localparam crop_sum_t c_rows = crop_sum_t'(IN_ROWS);

  crop_win_t pend_q;
  crop_win_t act_q;
  logic      err_q;
  crop_win_t w_cfg;
  logic      w_cfg_ok;

  assign w_cfg = '{
    x1: crop_dim_t'(cfg_x1_i),
    y1: crop_dim_t'(cfg_y1_i),
    w:  crop_dim_t'(cfg_w_i),
    h:  crop_dim_t'(cfg_h_i)
  };
  assign w_cfg_ok = crop_win_ok(w_cfg, c_cols, c_rows);

  // Pending takes legal writes; active samples the old pending on load, so
  // a write coinciding with a load only affects the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= c_def_win;
      act_q  <= c_def_win;
      err_q  <= 1'b0;
    end else begin
      err_q <= cfg_wr_i && !w_cfg_ok;
      if (cfg_wr_i && w_cfg_ok) pend_q <= w_cfg;
      if (load_i) act_q <= pend_q;
    end
  end

  assign act_win_o = act_q;
  assign cfg_err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/crop_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : crop_frame_ctrl                                           |
// | Purpose  : Frame sequencer for the crop datapath. Tracks raster      |
// |            position, applies the active window and emits a          |
// |            registered cropped stream with SOF/EOL/EOF markers.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module crop_frame_ctrl
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int DEF_X1          = 10,
  parameter int DEF_Y1          = 10,
  parameter int DEF_W           = 20,
  parameter int DEF_H           = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         cfg_cont,
  input  logic                         cfg_wr,
  input  logic [$clog2(IN_COLS)-1:0]   cfg_x1,
  input  logic [$clog2(IN_ROWS)-1:0]   cfg_y1,
  input  logic [$clog2(IN_COLS+1)-1:0] cfg_w,
  input  logic [$clog2(IN_ROWS+1)-1:0] cfg_h,
  output logic                         cfg_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIXEL_BIT_WIDTH-1:0]   pixel_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PIXEL_BIT_WIDTH-1:0]   pixel_out,
  output logic                         out_sof,
  output logic                         out_eol,
  output logic                         out_eof,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int XW = $clog2(IN_COLS);
  localparam int YW = $clog2(IN_ROWS);
  localparam logic [XW-1:0] c_x_last = XW'(IN_COLS - 1);
  localparam logic [YW-1:0] c_y_last = YW'(IN_ROWS - 1);

  crop_state_e                state_q, state_d;
  logic [XW-1:0]              x_q;
  logic [YW-1:0]              y_q;
  crop_win_t                  act_win;
  logic                       win_load;
  logic                       out_free, beat, last_beat;
  logic                       frame_done_d, frame_done_q;
  crop_dim_t                  x_ext, y_ext, x_end, y_end;
  logic                       in_win, hit_eol;
  logic                       out_valid_q, sof_q, eol_q, eof_q;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_q;

  crop_window_regs #(
    .IN_ROWS (IN_ROWS),
    .IN_COLS (IN_COLS),
    .DEF_X1  (DEF_X1),
    .DEF_Y1  (DEF_Y1),
    .DEF_W   (DEF_W),
    .DEF_H   (DEF_H)
  ) u_window_regs (
    .clk       (clk),
    .reset     (reset),
    .cfg_wr_i  (cfg_wr),
    .cfg_x1_i  (cfg_x1),
    .cfg_y1_i  (cfg_y1),
    .cfg_w_i   (cfg_w),
    .cfg_h_i   (cfg_h),
    .load_i    (win_load),
    .act_win_o (act_win),
    .cfg_err_o (cfg_err)
  );

  // Window hit test in the wide window domain; x_end/y_end are exclusive.
  assign x_ext   = crop_dim_t'(x_q);
  assign y_ext   = crop_dim_t'(y_q);
  assign x_end   = act_win.x1 + act_win.w;
  assign y_end   = act_win.y1 + act_win.h;
  assign in_win  = (x_ext >= act_win.x1) && (x_ext < x_end) &&
                   (y_ext >= act_win.y1) && (y_ext < y_end);
  assign hit_eol = (x_ext == x_end - crop_dim_t'(1));

  // The output slot is free when empty or being drained this cycle.
  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && out_free;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (x_q == c_x_last) && (y_q == c_y_last);

  // Next-state logic, window load strobe and frame completion.
  always_comb begin
    state_d      = state_q;
    win_load     = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          win_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_free) begin
          frame_done_d = 1'b1;
          if (cfg_cont) begin
            state_d  = ST_RUN;
            win_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and frame_done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Raster counters advance once per accepted beat and wrap at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (beat) begin
      if (x_q == c_x_last) begin
        x_q <= '0;
        y_q <= (y_q == c_y_last) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Output register: loads in-window beats, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      pixel_q     <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else if (beat && in_win) begin
      out_valid_q <= 1'b1;
      pixel_q     <= pixel_in;
      sof_q       <= (x_ext == act_win.x1) && (y_ext == act_win.y1);
      eol_q       <= hit_eol;
      eof_q       <= hit_eol && (y_ext == y_end - crop_dim_t'(1));
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign pixel_out  = pixel_q;
  assign out_sof    = sof_q;
  assign out_eol    = eol_q;
  assign out_eof    = eof_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crop_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_crop_frame_ctrl                                        |
// | Purpose  : Directed self-checking bench for crop_frame_ctrl.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_crop_frame_ctrl;

  localparam int PW   = 12;
  localparam int ROWS = 40;
  localparam int COLS = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cfg_cont = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [5:0]    cfg_x1 = '0, cfg_y1 = '0, cfg_w = '0, cfg_h = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] pixel_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] pixel_out;
  logic          out_sof, out_eol, out_eof, frame_done, busy;

  int n_vec = 0;
  int n_err = 0;

  // Captured output stream and per-run observations.
  int         q_pix[$];
  logic [2:0] q_mk[$];
  int         e_pix[$];
  logic [2:0] e_mk[$];
  int         n_done, n_stall_bad, n_rdy_bad, n_beats_done;
  bit         aborted;

  crop_frame_ctrl #(
    .PIXEL_BIT_WIDTH (PW), .IN_ROWS (ROWS), .IN_COLS (COLS),
    .DEF_X1 (10), .DEF_Y1 (10), .DEF_W (20), .DEF_H (20)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .cfg_cont (cfg_cont),
    .cfg_wr (cfg_wr), .cfg_x1 (cfg_x1), .cfg_y1 (cfg_y1), .cfg_w (cfg_w),
    .cfg_h (cfg_h), .cfg_err (cfg_err), .in_valid (in_valid),
    .in_ready (in_ready), .pixel_in (pixel_in), .out_valid (out_valid),
    .out_ready (out_ready), .pixel_out (pixel_out), .out_sof (out_sof),
    .out_eol (out_eol), .out_eof (out_eof), .frame_done (frame_done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference model: raster-order pixel indices of a window, with markers.
  function automatic void add_exp(input int x1, input int y1, input int w, input int h);
    for (int y = y1; y < y1 + h; y++) begin
      for (int x = x1; x < x1 + w; x++) begin
        e_pix.push_back(y * COLS + x);
        e_mk.push_back({(x == x1 && y == y1), (x == x1 + w - 1),
                        (x == x1 + w - 1 && y == y1 + h - 1)});
      end
    end
  endfunction

  function automatic int seq_diffs();
    int d = 0;
    for (int i = 0; i < q_pix.size() && i < e_pix.size(); i++)
      if (q_pix[i] != e_pix[i] || q_mk[i] !== e_mk[i]) d++;
    return d;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic cfg_write(input int x1, input int y1, input int w, input int h);
    @(negedge clk);
    cfg_x1 = 6'(x1); cfg_y1 = 6'(y1); cfg_w = 6'(w); cfg_h = 6'(h);
    cfg_wr = 1'b1;
    @(negedge clk); cfg_wr = 1'b0;
  endtask

  // Feeds pixel indices (modulo frame size) and records every output
  // handshake; stops once enough beats went in and enough frames finished.
  task automatic drive(input int n_beats, input int n_frames, input bit rnd,
                       input int wr_at, input int clr_cont_at,
                       input int abort_at, input int start_at);
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [PW-1:0] hold_pix = '0;
    logic [2:0]    hold_mk = '0;
    q_pix.delete(); q_mk.delete();
    n_done = 0; n_stall_bad = 0; n_rdy_bad = 0; aborted = 1'b0;
    while (cyc < n_beats * 4 + 200) begin
      @(negedge clk); cyc++;
      if (frame_done) n_done++;
      if (prev_stall && (!out_valid || pixel_out !== hold_pix ||
                         {out_sof, out_eol, out_eof} !== hold_mk)) n_stall_bad++;
      if (idx >= n_beats && n_done >= n_frames) break;
      cfg_wr = 1'b0; start = 1'b0;
      if (idx == wr_at) begin cfg_wr = 1'b1; wr_at = -1; end
      if (idx == clr_cont_at) cfg_cont = 1'b0;
      if (idx == start_at) begin start = 1'b1; start_at = -1; end
      if (idx == abort_at) begin reset = 1'b1; in_valid = 1'b0; aborted = 1'b1; break; end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (idx < n_beats);
      pixel_in  = PW'(idx % (ROWS * COLS));
      #1;
      if (out_valid && !out_ready && in_ready) n_rdy_bad++;
      if (out_valid && out_ready) begin
        q_pix.push_back(int'(pixel_out));
        q_mk.push_back({out_sof, out_eol, out_eof});
      end
      prev_stall = out_valid && !out_ready;
      hold_pix   = pixel_out;
      hold_mk    = {out_sof, out_eol, out_eof};
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1; cfg_wr = 1'b0; start = 1'b0;
    n_beats_done = idx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({out_valid, out_sof, out_eol, out_eof, frame_done, cfg_err, busy} !== 7'b0 ||
        pixel_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v/sof/eol/eof/done/err/busy=%b pix=%0d, need all 0",
               {out_valid, out_sof, out_eol, out_eof, frame_done, cfg_err, busy}, pixel_out);
    end
    reset = 1'b0; in_valid = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL idle_in_ready: got %b need 0", in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_default_frame();
    pulse_start();
    drive(1600, 1, 1'b0, -1, -1, -1, -1);
    e_pix.delete(); e_mk.delete(); add_exp(10, 10, 20, 20);
    n_vec++;
    if (q_pix.size() != 400) begin
      n_err++; $display("FAIL default_count: got %0d need 400", q_pix.size());
    end
    n_vec++;
    if (q_pix.size() == 0 || q_pix[0] != 410 || q_mk[0] !== 3'b100) begin
      n_err++; $display("FAIL default_first: got pix=%0d mk=%b need 410 mk=100",
                        q_pix.size() ? q_pix[0] : -1, q_mk.size() ? q_mk[0] : 3'bx);
    end
    n_vec++;
    if (q_pix.size() == 0 || q_pix[$] != 1189 || q_mk[$] !== 3'b011) begin
      n_err++; $display("FAIL default_last: got pix=%0d mk=%b need 1189 mk=011",
                        q_pix.size() ? q_pix[$] : -1, q_mk.size() ? q_mk[$] : 3'bx);
    end
    n_vec++;
    if (seq_diffs() != 0) begin
      n_err++; $display("FAIL default_seq: got %0d differing outputs need 0", seq_diffs());
    end
    @(negedge clk); #1;
    n_vec++;
    if (n_done != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL default_done: got done=%0d busy=%b need 1 and 0", n_done, busy);
    end
  endtask

  task automatic test_stall_frame();
    pulse_start();
    drive(1600, 1, 1'b1, -1, -1, -1, -1);
    e_pix.delete(); e_mk.delete(); add_exp(10, 10, 20, 20);
    n_vec++;
    if (q_pix.size() != 400 || seq_diffs() != 0) begin
      n_err++; $display("FAIL stall_seq: got count=%0d diffs=%0d need 400 and 0",
                        q_pix.size(), seq_diffs());
    end
    n_vec++;
    if (n_stall_bad != 0 || n_rdy_bad != 0) begin
      n_err++; $display("FAIL stall_hold: got unstable=%0d ready_under_stall=%0d need 0 and 0",
                        n_stall_bad, n_rdy_bad);
    end
    n_vec++;
    if (n_done != 1) begin
      n_err++; $display("FAIL stall_done: got %0d need 1", n_done);
    end
  endtask

  task automatic test_cfg();
    cfg_write(30, 10, 11, 20); #1;
    n_vec++;
    if (cfg_err !== 1'b1) begin
      n_err++; $display("FAIL cfg_reject_x: got cfg_err=%b need 1", cfg_err);
    end
    @(negedge clk); #1;
    n_vec++;
    if (cfg_err !== 1'b0) begin
      n_err++; $display("FAIL cfg_err_pulse: got cfg_err=%b need 0", cfg_err);
    end
    cfg_write(10, 10, 0, 20); #1;
    n_vec++;
    if (cfg_err !== 1'b1) begin
      n_err++; $display("FAIL cfg_reject_w0: got cfg_err=%b need 1", cfg_err);
    end
    pulse_start();
    drive(1600, 1, 1'b0, -1, -1, -1, -1);
    e_pix.delete(); e_mk.delete(); add_exp(10, 10, 20, 20);
    n_vec++;
    if (q_pix.size() != 400 || seq_diffs() != 0) begin
      n_err++; $display("FAIL cfg_pending_kept: got count=%0d diffs=%0d need 400 and 0",
                        q_pix.size(), seq_diffs());
    end
    cfg_write(0, 0, 40, 40); #1;
    n_vec++;
    if (cfg_err !== 1'b0) begin
      n_err++; $display("FAIL cfg_accept_full: got cfg_err=%b need 0", cfg_err);
    end
    pulse_start();
    drive(1600, 1, 1'b0, -1, -1, -1, -1);
    e_pix.delete(); e_mk.delete(); add_exp(0, 0, 40, 40);
    n_vec++;
    if (q_pix.size() != 1600 || seq_diffs() != 0 || q_mk[$] !== 3'b011) begin
      n_err++; $display("FAIL cfg_full_frame: got count=%0d diffs=%0d need 1600 and 0",
                        q_pix.size(), seq_diffs());
    end
  endtask

  task automatic test_cont_mode();
    cfg_write(10, 10, 20, 20);
    cfg_x1 = 6'd5; cfg_y1 = 6'd5; cfg_w = 6'd1; cfg_h = 6'd1;
    cfg_cont = 1'b1;
    pulse_start();
    drive(3200, 2, 1'b0, 800, 2000, -1, -1);
    e_pix.delete(); e_mk.delete(); add_exp(10, 10, 20, 20); add_exp(5, 5, 1, 1);
    n_vec++;
    if (q_pix.size() != 401 || seq_diffs() != 0) begin
      n_err++; $display("FAIL cont_seq: got count=%0d diffs=%0d need 401 and 0",
                        q_pix.size(), seq_diffs());
    end
    n_vec++;
    if (q_pix.size() == 0 || q_pix[$] != 205 || q_mk[$] !== 3'b111) begin
      n_err++; $display("FAIL cont_1x1: got pix=%0d mk=%b need 205 mk=111",
                        q_pix.size() ? q_pix[$] : -1, q_mk.size() ? q_mk[$] : 3'bx);
    end
    @(negedge clk); #1;
    n_vec++;
    if (n_done != 2 || busy !== 1'b0) begin
      n_err++; $display("FAIL cont_done: got done=%0d busy=%b need 2 and 0", n_done, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int late_done = 0;
    pulse_start();
    drive(1600, 1, 1'b0, -1, -1, 700, -1);
    @(negedge clk); #1;
    n_vec++;
    if (!aborted || {out_valid, out_sof, out_eol, out_eof, busy} !== 5'b0 || pixel_out !== '0) begin
      n_err++; $display("FAIL abort_outputs: got v/sof/eol/eof/busy=%b pix=%0d aborted=%0d need 0",
                        {out_valid, out_sof, out_eol, out_eof, busy}, pixel_out, aborted);
    end
    reset = 1'b0;
    repeat (5) begin @(negedge clk); if (frame_done) late_done++; end
    n_vec++;
    if (n_done + late_done != 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d pulses need 0", n_done + late_done);
    end
    pulse_start();
    drive(1600, 1, 1'b0, -1, -1, -1, -1);
    e_pix.delete(); e_mk.delete(); add_exp(10, 10, 20, 20);
    n_vec++;
    if (q_pix.size() != 400 || seq_diffs() != 0 || n_done != 1) begin
      n_err++; $display("FAIL abort_restart: got count=%0d diffs=%0d done=%0d need 400 0 1",
                        q_pix.size(), seq_diffs(), n_done);
    end
  endtask

  task automatic test_start_during_run();
    int extra = 0;
    pulse_start();
    drive(1600, 1, 1'b0, -1, -1, -1, 500);
    e_pix.delete(); e_mk.delete(); add_exp(10, 10, 20, 20);
    n_vec++;
    if (q_pix.size() != 400 || seq_diffs() != 0 || n_done != 1) begin
      n_err++; $display("FAIL start_in_run: got count=%0d diffs=%0d done=%0d need 400 0 1",
                        q_pix.size(), seq_diffs(), n_done);
    end
    repeat (20) begin @(negedge clk); if (frame_done || busy) extra++; end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL start_in_run_idle: got %0d busy/done cycles need 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_stall_frame();
    test_cfg();
    test_cont_mode();
    test_reset_mid_frame();
    test_start_during_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
